sensor_sample_feeder: RTL

Upstream partner of the isolation-tree anomaly detector. It buffers raw 8-bit sensor samples in a small FIFO and presents them one at a time on the detector's data/valid interface. It holds each sample until the detector signals data_processed, then captures the anomaly verdict and reports it with the sample on a result port. It also keeps a saturating anomaly count and aborts hung transactions with a timeout.

---
 rtl/sensor_sample_feeder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sensor_sample_feeder.sv
`default_nettype none
// ============================================================================
// sensor_sample_feeder : FIFO-buffered sample feeder for the isolation-tree
//                        detector with verdict reporting, count and timeout.
// Revision            : 1.0
// ============================================================================
module sensor_sample_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       sample_in,
  input  logic             sample_wr,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             overflow,
  output logic [7:0]       tree_data,
  output logic             tree_valid,
  input  logic             tree_processed,
  input  logic             tree_anomaly,
  output logic             result_valid,
  output logic [7:0]       result_data,
  output logic             result_anomaly,
  output logic             result_timeout,
  output logic [CNT_W-1:0] anomaly_count,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESENT = 2'd1;
  localparam logic [1:0] S_RESULT  = 2'd2;

  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [AW:0]      DEPTH_C  = (AW + 1)'(DEPTH);

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;

  // Transaction state
  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [7:0]       tree_data_q, tree_data_d;
  logic             tree_valid_q, tree_valid_d;
  logic [7:0]       res_data_q, res_data_d;
  logic             res_anom_q, res_anom_d;
  logic             res_tmo_q, res_tmo_d;
  logic [CNT_W-1:0] anom_cnt_q, anom_cnt_d;

  logic pop;
  logic push;
  logic drop;

  // A full FIFO still accepts a write when the FSM pops on the same edge.
  assign pop  = (state_q == S_IDLE) && !empty_q;
  assign push = sample_wr && (!full_q || pop);
  assign drop = sample_wr && full_q && !pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  assign wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign full_d     = (count_d == DEPTH_C);
  assign empty_d    = (count_d == '0);
  assign overflow_d = overflow_q || drop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    tree_data_d  = tree_data_q;
    tree_valid_d = tree_valid_q;
    res_data_d   = res_data_q;
    res_anom_d   = res_anom_q;
    res_tmo_d    = res_tmo_q;
    anom_cnt_d   = anom_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          tree_data_d  = mem_q[rd_ptr_q];
          tree_valid_d = 1'b1;
          timer_d      = '0;
          state_d      = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (tree_processed) begin
          res_data_d   = tree_data_q;
          res_anom_d   = tree_anomaly;
          res_tmo_d    = 1'b0;
          tree_valid_d = 1'b0;
          state_d      = S_RESULT;
        end else if (timer_q == TMO_LAST) begin
          res_data_d   = tree_data_q;
          res_anom_d   = 1'b0;
          res_tmo_d    = 1'b1;
          tree_valid_d = 1'b0;
          state_d      = S_RESULT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESULT: begin
        if (res_anom_q && (anom_cnt_q != CNT_MAX)) begin
          anom_cnt_d = anom_cnt_q + CNT_W'(1);
        end
        state_d = S_IDLE;
      end
      default: begin
        tree_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      tree_data_q  <= '0;
      tree_valid_q <= 1'b0;
      res_data_q   <= '0;
      res_anom_q   <= 1'b0;
      res_tmo_q    <= 1'b0;
      anom_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      tree_data_q  <= tree_data_d;
      tree_valid_q <= tree_valid_d;
      res_data_q   <= res_data_d;
      res_anom_q   <= res_anom_d;
      res_tmo_q    <= res_tmo_d;
      anom_cnt_q   <= anom_cnt_d;
    end
  end

  assign fifo_full      = full_q;
  assign fifo_empty     = empty_q;
  assign overflow       = overflow_q;
  assign tree_data      = tree_data_q;
  assign tree_valid     = tree_valid_q;
  assign result_valid   = (state_q == S_RESULT);
  assign result_data    = res_data_q;
  assign result_anomaly = res_anom_q;
  assign result_timeout = res_tmo_q;
  assign anomaly_count  = anom_cnt_q;
  assign busy           = (state_q != S_IDLE);

endmodule
`default_nettype wire
